wb_pipe: RTL and testbench
==========================

# wb_pipe

Registered, parametrised writeback stage for the RISC-V core. It replaces the purely combinational writeback select with a stage that accepts one instruction per cycle and waits on variable-latency DMEM/BIOS load responses. It also performs byte/halfword load alignment with sign or zero extension, drives the register-file write port, and keeps a retired-instruction counter and a sticky load-timeout flag. It sits between the ex/mem pipeline register and the register file.

## Interface
- `DATA_W`, 32: datapath width; must be 32.
- `RADDR_W`, 5: register address width.
- `CNT_W`, 32: width of the instret counter.
- `LOAD_TIMEOUT`, 16: maximum cycles to wait for a load response; must be ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid_i` in 1: upstream holds a valid instruction.
- `in_ready_o` out 1: stage can accept an instruction.
- `alu_result_i` in DATA_W: ALU result, also used as the load address.
- `pc_plus_i` in DATA_W: PC+4.
- `wb_addr_i` in RADDR_W: destination register (rd).
- `wb_en_i` in 1: instruction writes rd.
- `wb_sel_i` in 2: writeback source; 0 = ALU, 1 = LOAD, 2 = PC+4, 3 = zero.
- `load_funct3_i` in 3: load type.
- `mem_rvalid_i` in 1: load data valid this cycle.
- `dmem_rdata_i` in DATA_W: DMEM read word.
- `bios_rdata_i` in DATA_W: BIOS read word.
- `rf_we_o` out 1: register-file write enable.
- `rf_waddr_o` out RADDR_W: register-file write address.
- `rf_wdata_o` out DATA_W: register-file write data.
- `instret_o` out CNT_W: count of retired instructions.
- `err_o` out 1: sticky load-timeout flag.

## Operation
- States: IDLE and WAIT_MEM.
- `in_ready_o` = (state == IDLE) and not `rst`.
- An instruction is accepted when `in_valid_i` and `in_ready_o` are both high. On acceptance, latch `alu_result_i`, `pc_plus_i`, `wb_addr_i`, `wb_en_i`, `wb_sel_i` and `load_funct3_i`.
- Accepted non-load (`wb_sel` ≠ 1): retire next cycle and stay in IDLE.
- Accepted load: go to WAIT_MEM and clear the wait counter.
- In WAIT_MEM, on `mem_rvalid_i`:
  - Select the source word by `addr[31:28]`: 4'h1 or 4'h3 → DMEM, 4'h4 → BIOS, anything else → 0.
  - Align the word, retire, and return to IDLE.
- Load alignment, with byte offset `addr[1:0]`:
  - 000 (LB): sign-extend byte at the offset.
  - 100 (LBU): zero-extend byte at the offset.
  - 001 (LH): sign-extend half selected by `addr[1]`.
  - 101 (LHU): zero-extend half selected by `addr[1]`.
  - 010 (LW): full word; `addr[1:0]` ignored.
  - Any other funct3: data 0.
- Timeout: the wait counter increments on each WAIT_MEM cycle without `mem_rvalid_i`. When it reaches `LOAD_TIMEOUT`, retire with data 0, set `err_o`, and return to IDLE.
- Retirement:
  - `rf_we_o` = `wb_en` and (rd ≠ 0), pulsed for exactly one cycle.
  - `rf_waddr_o` and `rf_wdata_o` are valid in that cycle and hold their values afterwards.
  - `instret_o` increments on every retirement, including rd = 0 and timed-out loads, and wraps modulo 2^CNT_W.
- `mem_rvalid_i` is ignored in IDLE, including stale responses after a timeout or reset.

## Timing
- Reset values: state IDLE, `rf_we_o` 0, `rf_waddr_o` 0, `rf_wdata_o` 0, `instret_o` 0, `err_o` 0, wait counter 0. `in_ready_o` is 0 while `rst` is high.
- Reset mid-load: the load is abandoned with no write and no instret increment.
- Non-load accepted at cycle N: `rf_we_o` is high in N+1. Throughput is 1 per cycle.
- Load accepted at N with `mem_rvalid_i` at M (M ≥ N+1): `rf_we_o` is high in M+1. `in_ready_o` stays low from N+1 through M and is high at M+1.
- Timeout: retirement lands exactly `LOAD_TIMEOUT`+1 cycles after acceptance.
- `rst` and `in_valid_i` high in the same cycle: reset wins and nothing is accepted.

## Structure
- Add to `defines.vh`:
  - `wb_sel` encodings: WB_ALU, WB_LOAD, WB_PC4, WB_ZERO.
  - Load funct3 codes.
  - Region nibbles: REGION_DMEM0 = 4'h1, REGION_DMEM1 = 4'h3, REGION_BIOS = 4'h4.
  - State encodings.
- One combinational sub-module, `load_align`: inputs word, `addr[1:0]`, funct3; output the aligned, extended `DATA_W` value.

## Test plan
- ALU op: `wb_sel`=0, `alu_result`=0x12345678, rd=5, accepted at N → `rf_we_o`=1 at N+1, `rf_waddr_o`=5, `rf_wdata_o`=0x12345678, `instret_o`=1.
- LB: addr 0x10000003, DMEM word 0x80FF00AA, `mem_rvalid_i` at N+1 → `rf_wdata_o`=0xFFFFFF80 at N+2. Repeat as LBU → 0x00000080. Repeat as LH at addr 0x10000002 → 0xFFFF80FF.
- BIOS LW: addr 0x40000010, `bios_rdata_i`=0xDEADBEEF, `mem_rvalid_i` 3 cycles after acceptance → `in_ready_o` low for 3 cycles, then `rf_wdata_o`=0xDEADBEEF.
- rd=0 JAL: `wb_sel`=2, `pc_plus`=0x104 → `rf_we_o` stays 0 and `instret_o` increments.
- Timeout: load with no `mem_rvalid_i` → retire with data 0 and `err_o`=1 at acceptance + 17 cycles (`LOAD_TIMEOUT`=16). A late `mem_rvalid_i` afterwards produces no write.
- Reset mid-load: `rst` asserted while in WAIT_MEM → no write, `instret_o`=0, `in_ready_o`=1 the cycle after `rst` deasserts.

Source files
------------

// File: rtl/wb_pipe_pkg.sv
// rtl/wb_pipe_pkg.sv - shared encodings for the wb_pipe writeback stage
// Purpose: writeback-source codes, load funct3 codes, memory region
//          nibbles, FSM state encoding and the region source-word select.
// Ports:   none (package)
package wb_pipe_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_ZERO = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] REGION_DMEM0 = 4'h1;
  localparam logic [3:0] REGION_DMEM1 = 4'h3;
  localparam logic [3:0] REGION_BIOS  = 4'h4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

  // Unmapped regions read as zero.
  function automatic logic [31:0] region_word(input logic [3:0]  nib,
                                              input logic [31:0] dmem,
                                              input logic [31:0] bios);
    case (nib)
      REGION_DMEM0, REGION_DMEM1: return dmem;
      REGION_BIOS:                return bios;
      default:                    return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/wb_pipe_if.sv
// rtl/wb_pipe_if.sv - instruction, memory-response and register-file bus of wb_pipe
// Purpose: bundles the upstream handshake/instruction fields, the load
//          response inputs and the register-file / status outputs.
// Modports: master = upstream + memory side, slave = wb_pipe.
interface wb_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
);
  logic               in_valid_i;
  logic               in_ready_o;
  logic [DATA_W-1:0]  alu_result_i;
  logic [DATA_W-1:0]  pc_plus_i;
  logic [RADDR_W-1:0] wb_addr_i;
  logic               wb_en_i;
  logic [1:0]         wb_sel_i;
  logic [2:0]         load_funct3_i;
  logic               mem_rvalid_i;
  logic [DATA_W-1:0]  dmem_rdata_i;
  logic [DATA_W-1:0]  bios_rdata_i;
  logic               rf_we_o;
  logic [RADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0]  rf_wdata_o;
  logic [CNT_W-1:0]   instret_o;
  logic               err_o;

  modport master (
    output in_valid_i, alu_result_i, pc_plus_i, wb_addr_i, wb_en_i, wb_sel_i,
           load_funct3_i, mem_rvalid_i, dmem_rdata_i, bios_rdata_i,
    input  in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, instret_o, err_o
  );

  modport slave (
    input  in_valid_i, alu_result_i, pc_plus_i, wb_addr_i, wb_en_i, wb_sel_i,
           load_funct3_i, mem_rvalid_i, dmem_rdata_i, bios_rdata_i,
    output in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, instret_o, err_o
  );
endinterface

// File: rtl/wb_pipe_load_align.sv
// rtl/wb_pipe_load_align.sv - load byte/half extraction with sign or zero extension
// Purpose: combinational alignment of a memory word for LB/LBU/LH/LHU/LW.
// Ports:   word_i (memory word), offset_i (addr[1:0]), funct3_i (load type),
//          data_o (aligned, extended value; 0 for unsupported funct3).
module load_align
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        offset_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] data_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{offset_i, 3'b000} +: 8];
    half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(DATA_W-8){byte_v[7]}}, byte_v};
      F3_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_v};
      F3_LH:   data_o = {{(DATA_W-16){half_v[15]}}, half_v};
      F3_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_v};
      F3_LW:   data_o = word_i;
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/wb_pipe.sv
// rtl/wb_pipe.sv - registered writeback stage with variable-latency load wait
// Purpose: accepts one instruction per cycle, waits for DMEM/BIOS load data
//          (with timeout), aligns loads, drives the register-file write port,
//          counts retired instructions and flags load timeouts.
// Ports:   clk, rst (sync, active high), bus (wb_pipe_if.slave).
module wb_pipe
  import wb_pipe_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int RADDR_W      = 5,
  parameter int CNT_W        = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input logic    clk,
  input logic    rst,
  wb_pipe_if.slave bus
);
  localparam int WCNT_W = $clog2(LOAD_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [3:0]         region_q;
  logic [1:0]         offset_q;
  logic [2:0]         funct3_q;
  logic [RADDR_W-1:0] rd_q;
  logic               wen_q;
  logic [WCNT_W-1:0]  wait_q;

  logic               accept;
  logic               retire;
  logic               retire_en;
  logic               timeout;
  logic [RADDR_W-1:0] retire_addr;
  logic [DATA_W-1:0]  retire_data;
  logic [DATA_W-1:0]  aligned;

  assign bus.in_ready_o = (state_q == ST_IDLE) && !rst;
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  load_align #(.DATA_W(DATA_W)) u_align (
    .word_i   (region_word(region_q, bus.dmem_rdata_i, bus.bios_rdata_i)),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .data_o   (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Non-loads retire straight from the input fields on the accepting edge;
  // loads retire from the latched fields once data arrives or time runs out.
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    retire_en   = 1'b0;
    timeout     = 1'b0;
    retire_addr = rd_q;
    retire_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.wb_sel_i == WB_LOAD) begin
            state_d = ST_WAIT_MEM;
          end else begin
            retire      = 1'b1;
            retire_en   = bus.wb_en_i;
            retire_addr = bus.wb_addr_i;
            case (bus.wb_sel_i)
              WB_ALU:  retire_data = bus.alu_result_i;
              WB_PC4:  retire_data = bus.pc_plus_i;
              WB_ZERO: retire_data = '0;
              default: retire_data = '0;
            endcase
          end
        end
      end
      ST_WAIT_MEM: begin
        // A response in the last allowed cycle still beats the timeout.
        if (bus.mem_rvalid_i) begin
          retire      = 1'b1;
          retire_en   = wen_q;
          retire_data = aligned;
          state_d     = ST_IDLE;
        end else if (wait_q == WCNT_W'(LOAD_TIMEOUT - 1)) begin
          retire    = 1'b1;
          retire_en = wen_q;
          timeout   = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_we_o    <= 1'b0;
      bus.rf_waddr_o <= '0;
      bus.rf_wdata_o <= '0;
      bus.instret_o  <= '0;
      bus.err_o      <= 1'b0;
      region_q       <= '0;
      offset_q       <= '0;
      funct3_q       <= '0;
      rd_q           <= '0;
      wen_q          <= 1'b0;
      wait_q         <= '0;
    end else begin
      bus.rf_we_o <= retire && retire_en && (retire_addr != '0);
      if (retire) begin
        bus.rf_waddr_o <= retire_addr;
        bus.rf_wdata_o <= retire_data;
        bus.instret_o  <= bus.instret_o + 1'b1;
      end
      if (timeout) bus.err_o <= 1'b1;
      if (accept) begin
        region_q <= bus.alu_result_i[31:28];
        offset_q <= bus.alu_result_i[1:0];
        funct3_q <= bus.load_funct3_i;
        rd_q     <= bus.wb_addr_i;
        wen_q    <= bus.wb_en_i;
        wait_q   <= '0;
      end else if (state_q == ST_WAIT_MEM && !bus.mem_rvalid_i) begin
        wait_q <= wait_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_pipe.sv
// tb/tb_wb_pipe.sv - self-checking bench for wb_pipe
module tb_wb_pipe;
  localparam int TO = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_cnt;
  logic        exp_err;

  wb_pipe_if #(.DATA_W(32), .RADDR_W(5), .CNT_W(32)) bus ();

  wb_pipe #(.DATA_W(32), .RADDR_W(5), .CNT_W(32), .LOAD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr, input logic [31:0] dw,
                                           input logic [31:0] bw);
    int unsigned nib;
    nib = addr >> 28;
    if (nib == 1 || nib == 3) return dw;
    if (nib == 4) return bw;
    return 32'd0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] f3);
    int unsigned b, h;
    b = (word >> (8 * (addr % 4))) % 256;
    h = (word >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      3'd2:    return word;
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge with the stage idle. lat = cycles from acceptance
  // to mem_rvalid_i; lat > TO means the response never comes in time.
  task automatic run_txn(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pc,
                         input logic [4:0] rd, input logic en, input logic [2:0] f3,
                         input int lat, input logic [31:0] dw, input logic [31:0] bw);
    logic [31:0] exp_d;
    logic        exp_we;
    logic        to;
    int          ret;
    check("ready_at_issue", {31'd0, bus.in_ready_o}, 32'd1);
    bus.in_valid_i    = 1'b1;
    bus.wb_sel_i      = sel;
    bus.alu_result_i  = alu;
    bus.pc_plus_i     = pc;
    bus.wb_addr_i     = rd;
    bus.wb_en_i       = en;
    bus.load_funct3_i = f3;
    bus.dmem_rdata_i  = dw;
    bus.bios_rdata_i  = bw;
    to = 1'b0;
    if (sel == 2'd1) begin
      if (lat > TO) begin
        ret   = TO + 1;
        to    = 1'b1;
        exp_d = 32'd0;
      end else begin
        ret   = lat + 1;
        exp_d = ref_load(ref_word(alu, dw, bw), alu, f3);
      end
    end else begin
      ret   = 1;
      exp_d = (sel == 2'd0) ? alu : (sel == 2'd2) ? pc : 32'd0;
    end
    exp_we = en && (rd != 5'd0);
    for (int c = 1; c <= ret; c++) begin
      @(negedge clk);
      bus.in_valid_i   = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (c < ret) begin
        check("ready_low_wait", {31'd0, bus.in_ready_o}, 32'd0);
        check("no_we_wait", {31'd0, bus.rf_we_o}, 32'd0);
        if (c == lat) bus.mem_rvalid_i = 1'b1;
      end
    end
    exp_cnt = exp_cnt + 1;
    if (to) exp_err = 1'b1;
    check("rf_we", {31'd0, bus.rf_we_o}, {31'd0, exp_we});
    if (exp_we) begin
      check("rf_waddr", {27'd0, bus.rf_waddr_o}, {27'd0, rd});
      check("rf_wdata", bus.rf_wdata_o, exp_d);
    end
    check("instret", bus.instret_o, exp_cnt);
    check("err", {31'd0, bus.err_o}, {31'd0, exp_err});
    check("ready_after", {31'd0, bus.in_ready_o}, 32'd1);
    if (to) begin
      // Late response arrives while idle and must be ignored.
      bus.mem_rvalid_i = 1'b1;
      @(negedge clk);
      bus.mem_rvalid_i = 1'b0;
      check("stale_no_we", {31'd0, bus.rf_we_o}, 32'd0);
      check("stale_instret", bus.instret_o, exp_cnt);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  nibs [6];
    logic [1:0]  sel;
    logic [31:0] addr;
    n_checks = 0;
    n_errors = 0;
    exp_cnt  = 0;
    exp_err  = 0;
    nibs[0] = 4'h1; nibs[1] = 4'h3; nibs[2] = 4'h4;
    nibs[3] = 4'h0; nibs[4] = 4'h2; nibs[5] = 4'hF;
    clk = 1'b0;
    rst = 1'b1;
    bus.mem_rvalid_i = 1'b0;
    bus.dmem_rdata_i = '0;
    bus.bios_rdata_i = '0;
    // Valid instruction presented during reset must not be taken.
    bus.in_valid_i    = 1'b1;
    bus.wb_sel_i      = 2'd0;
    bus.alu_result_i  = 32'hCAFE0001;
    bus.pc_plus_i     = 32'h0;
    bus.wb_addr_i     = 5'd3;
    bus.wb_en_i       = 1'b1;
    bus.load_funct3_i = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.in_ready_o}, 32'd0);
    check("rst_we", {31'd0, bus.rf_we_o}, 32'd0);
    check("rst_waddr", {27'd0, bus.rf_waddr_o}, 32'd0);
    check("rst_wdata", bus.rf_wdata_o, 32'd0);
    check("rst_instret", bus.instret_o, 32'd0);
    check("rst_err", {31'd0, bus.err_o}, 32'd0);
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("rst_valid_no_we", {31'd0, bus.rf_we_o}, 32'd0);
    check("rst_valid_instret", bus.instret_o, 32'd0);

    // Directed cases
    run_txn(2'd0, 32'h12345678, 32'h0, 5'd5, 1'b1, 3'd0, 0, 32'h0, 32'h0);
    run_txn(2'd1, 32'h10000003, 32'h0, 5'd7, 1'b1, 3'd0, 1, 32'h80FF00AA, 32'h0);
    run_txn(2'd1, 32'h10000003, 32'h0, 5'd7, 1'b1, 3'd4, 1, 32'h80FF00AA, 32'h0);
    run_txn(2'd1, 32'h10000002, 32'h0, 5'd7, 1'b1, 3'd1, 1, 32'h80FF00AA, 32'h0);
    run_txn(2'd1, 32'h40000010, 32'h0, 5'd9, 1'b1, 3'd2, 3, 32'h0, 32'hDEADBEEF);
    run_txn(2'd2, 32'h0, 32'h00000104, 5'd0, 1'b1, 3'd0, 0, 32'h0, 32'h0);
    run_txn(2'd1, 32'h10000000, 32'h0, 5'd4, 1'b1, 3'd2, TO, 32'h11223344, 32'h0);
    run_txn(2'd1, 32'h10000000, 32'h0, 5'd4, 1'b1, 3'd2, TO + 1, 32'h11223344, 32'h0);

    // Reset while waiting on a load
    check("mid_ready", {31'd0, bus.in_ready_o}, 32'd1);
    bus.in_valid_i    = 1'b1;
    bus.wb_sel_i      = 2'd1;
    bus.alu_result_i  = 32'h10000000;
    bus.wb_addr_i     = 5'd6;
    bus.wb_en_i       = 1'b1;
    bus.load_funct3_i = 3'd2;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("mid_busy", {31'd0, bus.in_ready_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ready_in_rst", {31'd0, bus.in_ready_o}, 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    exp_err = 0;
    @(negedge clk);
    check("mid_ready_after", {31'd0, bus.in_ready_o}, 32'd1);
    check("mid_we", {31'd0, bus.rf_we_o}, 32'd0);
    check("mid_instret", bus.instret_o, 32'd0);
    check("mid_err", {31'd0, bus.err_o}, 32'd0);

    // Back-to-back non-loads: one retirement per cycle
    bus.in_valid_i = 1'b1;
    bus.wb_en_i    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.wb_sel_i     = (i % 2 == 0) ? 2'd0 : 2'd2;
      bus.alu_result_i = 32'hA000_0000 + 32'(i);
      bus.pc_plus_i    = 32'h0000_0100 + 32'(4 * i);
      bus.wb_addr_i    = 5'(i + 10);
      @(negedge clk);
      exp_cnt = exp_cnt + 1;
      check("b2b_ready", {31'd0, bus.in_ready_o}, 32'd1);
      check("b2b_we", {31'd0, bus.rf_we_o}, 32'd1);
      check("b2b_wdata", bus.rf_wdata_o,
            (i % 2 == 0) ? 32'hA000_0000 + 32'(i) : 32'h0000_0100 + 32'(4 * i));
      check("b2b_instret", bus.instret_o, exp_cnt);
    end
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("b2b_we_drop", {31'd0, bus.rf_we_o}, 32'd0);

    // Randomized transactions
    for (int k = 0; k < 60; k++) begin
      sel  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
      addr = {nibs[$urandom_range(0, 5)], 28'($urandom)};
      run_txn(sel, addr, $urandom, 5'($urandom), 1'($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0) ? $urandom_range(TO + 1, TO + 3) : $urandom_range(1, 6),
              $urandom, $urandom);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
